// File: rtl/uart_rx_fifo.sv
// UART receiver (runtime divider, 5..9 data bits, glitch/frame/break handling) feeding a
// first-word-fall-through receive FIFO. Define UART_RX_PARITY_EN to add one parity bit per frame.
module uart_rx_fifo #(
    parameter int unsigned CLKDIV     = 104,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    input  logic                   div_we,
    input  logic [15:0]            div_in,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [DATA_BITS-1:0]   rd_data,
    output logic                   rd_frame_err,
    output logic                   rd_parity_err,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   clr_overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam int unsigned DW = 16;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned EW = DATA_BITS + 2;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    localparam int unsigned EW = DATA_BITS + 1;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    logic [1:0]           r_sync;
    logic                 r_rx_prev;
    logic                 w_rx_s;
    logic                 w_fall;
    logic [DW-1:0]        r_div;
    logic [DW-1:0]        r_div_act;
    logic [DW-1:0]        w_div_act_n;
    logic [DW-1:0]        r_cnt;
    logic [DW-1:0]        w_cnt_n;
    logic [DW-1:0]        w_half;
    logic [DW-1:0]        w_reload;
    logic                 w_tick;
    state_t               r_state;
    state_t               w_state_n;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_n;
    logic [BW-1:0]        r_bit;
    logic [BW-1:0]        w_bit_n;
    logic                 w_push;
    logic [EW-1:0]        w_entry;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_err;
    logic                 w_par_err_n;
`else
    logic                 w_unused_par;
`endif

    // Two-flop synchronizer plus previous-value register for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], rx};
            r_rx_prev <= r_sync[1];
        end
    end

    assign w_rx_s = r_sync[1];
    assign w_fall = r_rx_prev & ~w_rx_s;

    // Programmed bit period; becomes active only at the next frame start
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= DW'(CLKDIV);
        end else if (div_we) begin
            r_div <= (div_in < 16'd4) ? 16'd4 : div_in;
        end
    end

    assign w_half   = {1'b0, r_div[DW-1:1]} - 16'd1;
    assign w_reload = r_div_act - 16'd1;
    assign w_tick   = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_div_act <= DW'(CLKDIV);
            r_shift   <= '0;
            r_bit     <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_err <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_div_act <= w_div_act_n;
            r_shift   <= w_shift_n;
            r_bit     <= w_bit_n;
`ifdef UART_RX_PARITY_EN
            r_par_err <= w_par_err_n;
`endif
        end
    end

    // Frame sequencing: every sample is taken where the down-counter reaches zero
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_div_act_n = r_div_act;
        w_shift_n   = r_shift;
        w_bit_n     = r_bit;
        w_push      = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_err_n = r_par_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_n   = S_START;
                    w_cnt_n     = w_half;
                    w_div_act_n = r_div;
                end
            end
            S_START: begin
                if (!w_tick) begin
                    w_cnt_n = r_cnt - 16'd1;
                end else if (w_rx_s) begin
                    w_state_n = S_IDLE;
                end else begin
                    w_state_n = S_DATA;
                    w_cnt_n   = w_reload;
                    w_bit_n   = '0;
                end
            end
            S_DATA: begin
                if (!w_tick) begin
                    w_cnt_n = r_cnt - 16'd1;
                end else begin
                    w_shift_n = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_cnt_n   = w_reload;
                    if (r_bit == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        w_state_n = S_PARITY;
`else
                        w_state_n = S_STOP;
`endif
                    end else begin
                        w_bit_n = r_bit + BW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (!w_tick) begin
                    w_cnt_n = r_cnt - 16'd1;
                end else begin
                    w_par_err_n = ^{r_shift, w_rx_s, 1'(PARITY_ODD)};
                    w_cnt_n     = w_reload;
                    w_state_n   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (!w_tick) begin
                    w_cnt_n = r_cnt - 16'd1;
                end else begin
                    w_push    = 1'b1;
                    w_state_n = w_rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (w_rx_s) begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign w_entry = {r_par_err, ~w_rx_s, r_shift};
`else
    assign w_entry      = {~w_rx_s, r_shift};
    assign w_unused_par = 1'(PARITY_ODD);
`endif

    logic [EW-1:0] r_mem [DEPTH];
    logic [LW-1:0] r_wr;
    logic [LW-1:0] r_rd;
    logic [LW-1:0] r_level;
    logic [LW-1:0] w_wr_n;
    logic [LW-1:0] w_rd_n;
    logic [LW-1:0] w_level_n;
    logic [EW-1:0] r_head;
    logic [EW-1:0] w_head_n;
    logic          r_valid;
    logic          r_ovf;
    logic          w_pop;
    logic          w_full;
    logic          w_push_ok;
    logic          w_ovf_set;

    // FIFO bookkeeping; a full FIFO still accepts a push when a pop happens in the same cycle
    always_comb begin
        w_pop     = r_valid & rd_ready;
        w_full    = (r_level == LW'(DEPTH));
        w_push_ok = w_push & (~w_full | w_pop);
        w_ovf_set = w_push & w_full & ~w_pop;
        w_wr_n    = r_wr + LW'(w_push_ok);
        w_rd_n    = r_rd + LW'(w_pop);
        w_level_n = w_wr_n - w_rd_n;
        if (w_push_ok && (w_rd_n[AW-1:0] == r_wr[AW-1:0])) begin
            w_head_n = w_entry;
        end else begin
            w_head_n = r_mem[w_rd_n[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr[AW-1:0]] <= w_entry;
        end
    end

    // Registered head entry, zeroed whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_valid <= 1'b0;
            r_head  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_wr    <= w_wr_n;
            r_rd    <= w_rd_n;
            r_level <= w_level_n;
            r_valid <= (w_level_n != '0);
            r_head  <= (w_level_n != '0) ? w_head_n : '0;
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (clr_overflow) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign rd_valid     = r_valid;
    assign rd_data      = r_head[DATA_BITS-1:0];
    assign rd_frame_err = r_head[DATA_BITS];
`ifdef UART_RX_PARITY_EN
    assign rd_parity_err = r_head[DATA_BITS+1];
`else
    assign rd_parity_err = 1'b0;
`endif
    assign level        = r_level;
    assign overflow     = r_ovf;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frame-level driver, queue-based FIFO model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_uart_rx_fifo;
    localparam int DB      = 8;
    localparam int DEPTH   = 16;
    localparam int CLKDIV  = 104;
    localparam int PAR_ODD = 0;

    typedef struct {
        logic [DB-1:0] data;
        logic          fe;
        logic          pe;
    } entry_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic          div_we;
    logic [15:0]   div_in;
    logic          rd_valid;
    logic          rd_ready;
    logic [DB-1:0] rd_data;
    logic          rd_frame_err;
    logic          rd_parity_err;
    logic [4:0]    level;
    logic          overflow;
    logic          clr_overflow;

    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc = 0;
    bit     started = 0;
    int     rise_cyc = -1;
    logic   prev_valid = 1'b0;
    logic   m_ovf = 1'b0;
    entry_t mq[$];
    entry_t pend_e[$];
    int     pend_c[$];

    uart_rx_fifo #(
        .CLKDIV(CLKDIV), .DATA_BITS(DB), .DEPTH(DEPTH), .PARITY_ODD(PAR_ODD)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .div_we(div_we), .div_in(div_in),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_frame_err(rd_frame_err), .rd_parity_err(rd_parity_err),
        .level(level), .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Model: entries land in the queue on their predicted stop-sample cycle
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                mq.delete();
                m_ovf = 1'b0;
            end else begin
                bit     pop;
                bit     push;
                entry_t e;
                pop  = (mq.size() > 0) && (rd_ready === 1'b1);
                push = 1'b0;
                if (pend_c.size() > 0 && pend_c[0] == cyc) begin
                    push = 1'b1;
                    e    = pend_e.pop_front();
                    void'(pend_c.pop_front());
                end
                if (pop) void'(mq.pop_front());
                if (push && mq.size() == DEPTH) begin
                    m_ovf = 1'b1;
                end else begin
                    if (push) mq.push_back(e);
                    if (clr_overflow === 1'b1) m_ovf = 1'b0;
                end
            end
            cyc++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                logic [DB-1:0] ed;
                logic          ef;
                logic          ep;
                ed = '0; ef = 1'b0; ep = 1'b0;
                if (mq.size() > 0) begin
                    ed = mq[0].data; ef = mq[0].fe; ep = mq[0].pe;
                end
                chk("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
                chk("level", 32'(level), 32'(mq.size()));
                chk("overflow", 32'(overflow), 32'(m_ovf));
                chk("rd_data", 32'(rd_data), 32'(ed));
                chk("rd_frame_err", 32'(rd_frame_err), 32'(ef));
                chk("rd_parity_err", 32'(rd_parity_err), 32'(ep));
                if (rd_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
                prev_valid = rd_valid;
            end
        end
    end

    // Drives one frame; act 1 pops and act 2 clears overflow on the push cycle
    task automatic send_frame(input logic [DB-1:0] data, input logic stop, input int d,
                              input bit has_par, input logic par, input int act,
                              output int t_start);
        int     p;
        int     nb;
        entry_t e;
        logic   b;
        @(negedge clk);
        t_start = cyc;
        nb = DB + 2 + (has_par ? 1 : 0);
        p  = t_start + 2 + d / 2 + (DB + 1 + (has_par ? 1 : 0)) * d;
        e.data = data;
        e.fe   = ~stop;
        e.pe   = has_par ? ((^data) ^ par ^ 1'(PAR_ODD)) : 1'b0;
        pend_c.push_back(p);
        pend_e.push_back(e);
        for (int j = 0; j < nb; j++) begin
            if (j == 0) b = 1'b0;
            else if (j <= DB) b = data[j-1];
            else if (has_par && j == DB + 1) b = par;
            else b = stop;
            rx = b;
            for (int k = 0; k < d; k++) begin
                rd_ready     = (act == 1 && cyc == p);
                clr_overflow = (act == 2 && cyc == p);
                @(negedge clk);
            end
        end
        rd_ready     = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic pop_check(input logic [DB-1:0] d, input logic fe, input logic pe);
        int n;
        n = 0;
        while (rd_valid !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("pop_wait", 32'(rd_valid), 32'd1);
        if (rd_valid === 1'b1) begin
            chk("pop_data", 32'(rd_data), 32'(d));
            chk("pop_frame_err", 32'(rd_frame_err), 32'(fe));
            chk("pop_parity_err", 32'(rd_parity_err), 32'(pe));
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        reset = 1'b1; rx = 1'b1; div_we = 1'b0; div_in = '0;
        rd_ready = 1'b0; clr_overflow = 1'b0;
        @(negedge clk);
        @(negedge clk);
        started = 1'b1;
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_valid", 32'(rd_valid), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single 8N1 byte with rd_valid rise time
        send_frame(8'h55, 1'b1, 104, 0, 1'b0, 0, t0);
        chk("rise_time", 32'(rise_cyc), 32'(t0 + 2 + 52 + 9 * 104 + 1));
        chk("t1_level", 32'(level), 32'd1);
        pop_check(8'h55, 1'b0, 1'b0);

        // Start-bit glitch
        @(negedge clk);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_level", 32'(level), 32'd0);
        chk("glitch_valid", 32'(rd_valid), 32'd0);

        // Frame error followed by a held-low line, then a pure break
        send_frame(8'hA3, 1'b0, 104, 0, 1'b0, 0, t0);
        repeat (2000) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("ferr_level", 32'(level), 32'd1);
        pop_check(8'hA3, 1'b1, 1'b0);
        send_frame(8'h00, 1'b0, 104, 0, 1'b0, 0, t0);
        repeat (2000) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("break_level", 32'(level), 32'd1);
        pop_check(8'h00, 1'b1, 1'b0);
        chk("break_empty", 32'(level), 32'd0);

        // Overflow with 17 frames and no pops
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 104, 0, 1'b0, 0, t0);
        repeat (5) @(negedge clk);
        chk("ovf_level", 32'(level), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) pop_check(8'(i), 1'b0, 1'b0);
        chk("ovf_drained", 32'(level), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Divider write mid-frame applies from the next frame, clamped to 4
        fork
            send_frame(8'h9A, 1'b1, 104, 0, 1'b0, 0, t0);
            begin
                repeat (500) @(negedge clk);
                div_we = 1'b1;
                div_in = 16'd2;
                @(negedge clk);
                div_we = 1'b0;
            end
        join
        pop_check(8'h9A, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 4, 0, 1'b0, 0, t0);
        pop_check(8'h3C, 1'b0, 1'b0);

        // Full-FIFO corner cases at D=8
        @(negedge clk);
        div_we = 1'b1;
        div_in = 16'd8;
        @(negedge clk);
        div_we = 1'b0;
        for (int i = 0; i < 16; i++) send_frame(8'(8'h80 + i), 1'b1, 8, 0, 1'b0, 0, t0);
        send_frame(8'hEE, 1'b1, 8, 0, 1'b0, 1, t0);
        chk("full_pushpop_level", 32'(level), 32'd16);
        chk("full_pushpop_ovf", 32'(overflow), 32'd0);
        send_frame(8'hEF, 1'b1, 8, 0, 1'b0, 2, t0);
        chk("clr_vs_ovf_level", 32'(level), 32'd16);
        chk("clr_vs_ovf_flag", 32'(overflow), 32'd1);
        for (int i = 1; i < 16; i++) pop_check(8'(8'h80 + i), 1'b0, 1'b0);
        pop_check(8'hEE, 1'b0, 1'b0);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;

        // Reset mid-frame restores the divider and discards the frame
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        send_frame(8'hC5, 1'b1, 104, 0, 1'b0, 0, t0);
        pop_check(8'hC5, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 104, 1, 1'b1, 0, t0);
        pop_check(8'h07, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 104, 1, 1'b0, 0, t0);
        pop_check(8'h07, 1'b0, 1'b1);
`endif

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Synthesizable, parametrised UART receiver with an integrated first-word-fall-through receive FIFO. It is the successor to the fixed 8N1, fixed-baud serial byte decoder used in simulation on `ser_tx`. It adds a runtime-programmable divider, configurable data width, start-bit glitch rejection, frame-error and break handling, optional parity, and buffering with overflow reporting. It sits in `ctrlsoc` beside the existing serial port, or in a bench as a monitor, and decodes a single asynchronous line in the `clk` domain.

## Interface
- `CLKDIV`, 104: reset value of the bit-period divider in `clk` cycles (12 MHz / 115200); minimum 4.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9.
- `DEPTH`, 16: FIFO entries; must be a power of two, at least 2.
- `PARITY_ODD`, 0: used only with `UART_RX_PARITY_EN`; 0 selects even parity, 1 selects odd.

- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idle high.
- `div_we`  in  1  loads `div_in` into the divider register.
- `div_in`  in  16  new bit period in cycles; values below 4 are stored as 4.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_ready`  in  1  pop strobe; pops when `rd_valid && rd_ready`.
- `rd_data`  out  DATA_BITS  head entry data, LSB = first received bit.
- `rd_frame_err`  out  1  head entry had stop bit = 0.
- `rd_parity_err`  out  1  head entry parity mismatch; tied 0 without the macro.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky; a frame was dropped because the FIFO was full.
- `clr_overflow`  in  1  clears `overflow`.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1. Edge detection compares the synchronized value with its previous value, also reset to 1.
- Divider register `div`: reset value `CLKDIV`. A write during a frame is latched but takes effect only on the next IDLE→START transition; the active value is copied at frame start.
- Bit counter `cnt` is 16 bits and counts down.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: a synchronized falling edge loads `cnt = div/2 - 1` (floor) and moves to START.
- START: at `cnt == 0`, sample the line. If it is 1, this is a glitch: return to IDLE and push nothing. If it is 0, load `cnt = div - 1` and go to DATA.
- DATA: sample at each `cnt == 0` and shift into the data register LSB-first. After `DATA_BITS` samples go to PARITY or STOP, reloading `div - 1` each bit.
- PARITY: sample one bit. The error is (XOR of data bits ^ sampled bit ^ `PARITY_ODD`) != 0.
- STOP: sample one bit and push {data, frame_err = !sample, parity_err} in the same cycle. If the sample is 1, go to IDLE. If it is 0, go to BREAK.
- BREAK: wait for synchronized rx = 1, then go to IDLE. No further pushes occur, so a break produces exactly one entry: data 0 with frame_err.
- FIFO push when full drops the frame and sets `overflow`. The exception: a push and a pop in the same cycle with the FIFO full is accepted, leaving `level` unchanged.
- Pop when empty is ignored.
- If `clr_overflow` and an overflowing push happen in the same cycle, `overflow` stays 1.
- Read and write pointers wrap modulo DEPTH. `level` is the difference of (log2 DEPTH + 1)-bit pointers.
- Reset mid-frame aborts the frame, returns the FSM to IDLE, empties the FIFO, and restores `div` to `CLKDIV`. No partial entry is pushed.

## Timing
- Reset values:
  - `rd_valid` = 0, `level` = 0, `overflow` = 0.
  - `rd_data`, `rd_frame_err`, and `rd_parity_err` are 0 when the FIFO is empty; their outputs are gated by `rd_valid`.
- Pin to detect: a falling `rx` is seen 2 cycles later (synchronizer delay). Call the detect cycle T0.
- Sample instants: start sample at T0 + D/2. Data bit k is sampled at T0 + D/2 + (k+1)·D. The stop bit is sampled at T0 + D/2 + (DATA_BITS+1)·D, plus an additional D when parity is enabled.
- Push occurs on the stop-sample cycle. `rd_valid` and `level` update on the following cycle.
- FIFO output is registered, fall-through: the head entry is visible in the same cycle as `rd_valid`. After a pop, the next entry appears on the next cycle.
- Back-to-back frames: a new start edge may be detected in the cycle after the STOP→IDLE transition.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists, frames carry one parity bit after the data, and `rd_parity_err` reflects a stored per-entry bit.
- Not defined: there is no PARITY state, no parity storage, `rd_parity_err` is constant 0, and `PARITY_ODD` is ignored.

## Test plan
- **Single 8N1 byte:** send 0x55 at D=104 → one entry: `rd_data` = 0x55, both error flags 0, `level` = 1, and `rd_valid` rises at T0 + 52 + 9·104 + 1.
- **Glitch rejection:** drive `rx` low for 30 cycles at D=104 → no entry, FSM back in IDLE, `level` = 0.
- **Framing and break:** send 0xA3 with stop bit 0, then hold `rx` low for 3000 cycles → exactly one entry {0xA3, frame_err = 1}. Then hold low 3000 cycles from a fresh start → one entry {0x00, frame_err = 1} only.
- **Overflow:** send 17 bytes 0x00..0x10 without popping at DEPTH=16 → `level` = 16, `overflow` = 1, and the pops return 0x00..0x0F. Pulsing `clr_overflow` then clears `overflow`.
- **Divider change and reset:** write `div_in` = 2 mid-frame. The current frame decodes at 104. The next frame decodes at D=4 (clamped); 0x3C received at D=4 → 0x3C. Assert `reset` in the middle of a frame → `level` = 0, no entry pushed, `div` = 104.
- **Parity (macro defined, `PARITY_ODD` = 0):** send 0x07 with parity bit 1 → `rd_parity_err` = 0. Send 0x07 with parity bit 0 → `rd_parity_err` = 1.
